// File: rtl/count_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module  : count_sample_fifo
// Samples a free-running counter on request into a show-ahead FIFO with
// valid/ready drain and sticky overflow. Define CNT_FIFO_WRAP_TAG_EN to add
// a counter-wrap tag bit as the MSB of each entry.
// Revision: 1.0
// ============================================================================
module count_sample_fifo #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              sample_en,
    input  logic              clr_ovf,
`ifdef CNT_FIFO_WRAP_TAG_EN
    output logic [WIDTH:0]    out_data,
`else
    output logic [WIDTH-1:0]  out_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

`ifdef CNT_FIFO_WRAP_TAG_EN
    localparam int c_dw = WIDTH + 1;
`else
    localparam int c_dw = WIDTH;
`endif
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    logic [c_dw-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [c_dw-1:0]   w_entry;
    logic [ADDR_W:0]   w_level_nxt;

    assign w_pop  = !r_empty && out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_push = sample_en && (!r_full || w_pop);
    assign w_drop = sample_en && !w_push;

`ifdef CNT_FIFO_WRAP_TAG_EN
    logic [WIDTH-1:0] r_prev_sample;

    assign w_entry = {(count_in < r_prev_sample), count_in};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev_sample <= '0;
        end else if (w_push) begin
            r_prev_sample <= count_in;
        end
    end
`else
    assign w_entry = count_in;
`endif

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + (ADDR_W + 1)'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - (ADDR_W + 1)'(1);
        end
    end

    // Storage is reset too so the show-ahead read is all-zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_depth);
            r_empty <= (w_level_nxt == '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = !r_empty;
    assign full      = r_full;
    assign empty     = r_empty;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_count_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_sample_fifo
// Directed and randomized bench for count_sample_fifo against a queue model.
// Revision: 1.0
// ============================================================================
module tb_count_sample_fifo;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
`ifdef CNT_FIFO_WRAP_TAG_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    logic              clk;
    logic              rstn;
    logic [WIDTH-1:0]  count_in;
    logic              sample_en;
    logic              clr_ovf;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    count_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .count_in  (count_in),
        .sample_en (sample_en),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus sticky flag and last sample.
    logic [DW-1:0]    mq[$];
    bit               m_ovf  = 1'b0;
    logic [WIDTH-1:0] m_prev = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = '0;
        end else begin
            bit            p_pop;
            bit            p_push;
            logic [DW-1:0] e;
            p_pop  = (mq.size() > 0) && out_ready;
            p_push = sample_en && ((mq.size() < DEPTH) || p_pop);
`ifdef CNT_FIFO_WRAP_TAG_EN
            e = {(count_in < m_prev), count_in};
`else
            e = count_in;
`endif
            if (p_pop) void'(mq.pop_front());
            if (p_push) begin
                mq.push_back(e);
                m_prev = count_in;
            end
            if (sample_en && !p_push) m_ovf = 1'b1;
            else if (clr_ovf)         m_ovf = 1'b0;
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_level", level, mq.size());
            chk("m_full", full, (mq.size() == DEPTH));
            chk("m_empty", empty, (mq.size() == 0));
            chk("m_valid", out_valid, (mq.size() != 0));
            chk("m_ovf", overflow, m_ovf);
            if (mq.size() != 0) chk("m_data", out_data, mq[0]);
        end
    end

    // Drive one cycle of inputs just after a falling edge; return after the next one.
    task automatic cyc(input logic se, input logic [WIDTH-1:0] cin, input logic rdy, input logic clr);
        sample_en = se;
        count_in  = cin;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sample_en = 1'b0; count_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        sample_en = 1'b0; count_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        #1;
        cmp_en = 1'b1;

        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);
        rstn = 1'b1;

        // Fill 3,4,5 then drain
        cyc(1'b1, 4'd3, 1'b0, 1'b0);
        chk("lat_valid", out_valid, 1);
        cyc(1'b1, 4'd4, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        chk("fill_level", level, 3);
        chk("fill_head", out_data[WIDTH-1:0], 3);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_head1", out_data[WIDTH-1:0], 4);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_head2", out_data[WIDTH-1:0], 5);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", empty, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pop_empty_lvl", level, 0);

        // Overflow: nine pushes, last dropped
        for (int i = 0; i < 9; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data[WIDTH-1:0], 0);
        cyc(1'b1, 4'd9, 1'b0, 1'b1);
        chk("ovf_set_wins", overflow, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clear", overflow, 0);

        // Push and pop together on a full FIFO
        cyc(1'b1, 4'd10, 1'b1, 1'b0);
        chk("fpp_level", level, 8);
        chk("fpp_ovf", overflow, 0);
        chk("fpp_head", out_data[WIDTH-1:0], 1);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fpp_tail", out_data[WIDTH-1:0], 10);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fpp_empty", empty, 1);

`ifdef CNT_FIFO_WRAP_TAG_EN
        // Wrap tags across the 15 -> 0 rollover
        do_reset();
        cyc(1'b1, 4'd14, 1'b0, 1'b0);
        cyc(1'b1, 4'd15, 1'b0, 1'b0);
        cyc(1'b1, 4'd0,  1'b0, 1'b0);
        cyc(1'b1, 4'd1,  1'b0, 1'b0);
        chk("tag_e0", out_data, 5'h0E);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("tag_e1", out_data, 5'h0F);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("tag_e2", out_data, 5'h10);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("tag_e3", out_data, 5'h01);
        cyc(1'b0, '0, 1'b1, 1'b0);
`endif

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) cyc(1'b1, WIDTH'(i + 2), 1'b0, 1'b0);
        chk("mid_level", level, 5);
        sample_en = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("mid_empty", empty, 1);
        chk("mid_level0", level, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        @(negedge clk);
        #1 rstn = 1'b1;
        cyc(1'b1, 4'd9, 1'b0, 1'b0);
        chk("post_rst_data", out_data[WIDTH-1:0], 9);
        chk("post_rst_valid", out_valid, 1);

        // Randomized traffic with varying drain pressure
        for (int ph = 0; ph < 4; ph++) begin
            int unsigned rdy_pct;
            rdy_pct = (ph == 0) ? 20 : (ph == 2) ? 85 : 50;
            for (int i = 0; i < 150; i++) begin
                cyc(($urandom_range(0, 99) < 60),
                    WIDTH'($urandom),
                    ($urandom_range(0, 99) < rdy_pct),
                    ($urandom_range(0, 99) < 6));
            end
        end
        idle();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
